uart_transceiver: RTL and testbench
===================================

// Module: uart_transceiver
// PURPOSE
//  Parametrised full-duplex UART: 8N1-style TX/RX engines, each with its own synchronous FIFO.
//  Next-generation replacement for the fixed 4-entry TX/RX buffer pair under the board top.
//  Top-level switch/button/display logic attaches through valid/ready ports.
//  Serial pins are txd/rxd.
// PARAMETERS
//  DATA_BITS     8      payload bits per frame (5..9), LSB first on the line
//  CLKS_PER_BIT  10416  clk cycles per bit (100 MHz / 9600); must be >= 4
//  DEPTH         4      entries per FIFO (power of 2, >= 2)
//  STOP_BITS     1      stop bits sent by TX (1 or 2); RX checks the first only
// PORTS
//  clk        in   1              system clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  tx_data    in   DATA_BITS      byte to transmit
//  tx_valid   in   1              push request into TX FIFO
//  tx_ready   out  1              TX FIFO not full
//  rx_data    out  DATA_BITS      head of RX FIFO (valid when rx_valid)
//  rx_valid   out  1              RX FIFO not empty
//  rx_ready   in   1              pop RX head
//  txd        out  1              serial out, idle high
//  rxd        in   1              serial in, asynchronous to clk
//  tx_count   out  $clog2(DEPTH+1)  TX FIFO occupancy
//  rx_count   out  $clog2(DEPTH+1)  RX FIFO occupancy
//  tx_busy    out  1              TX FSM not IDLE
//  frame_err  out  1              1-cycle pulse: RX stop bit sampled low
//  overrun    out  1              1-cycle pulse: RX byte completed while RX FIFO full
// BEHAVIOUR
//  Reset values (async assert, sync release): txd=1, tx_ready=1, rx_valid=0, rx_data=0.
//   Also tx_count=rx_count=0, tx_busy=0, frame_err=0, overrun=0; both FSMs IDLE, FIFOs emptied.
//  Reset mid-frame aborts the frame: txd returns high immediately, and any partial RX byte is discarded.
//  Handshake: transfer occurs on an edge where valid&&ready. tx_valid while !tx_ready is ignored.
//   rx_data is stable while rx_valid && !rx_ready.
//  FIFO: push and pop in the same cycle when full are both allowed; count unchanged. Pointers wrap mod DEPTH.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE pops when FIFO non-empty; a push at edge k into an empty FIFO drives txd low after edge k+2.
//   Each state lasts CLKS_PER_BIT cycles; DATA shifts DATA_BITS bits, LSB first.
//   STOP lasts STOP_BITS*CLKS_PER_BIT; a non-empty FIFO then goes straight to START (no idle gap).
//  RX: rxd passes a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: a falling edge starts the frame.
//   START: re-sample at CLKS_PER_BIT/2; if high, glitch -> IDLE with no flag.
//   Each following bit is sampled every CLKS_PER_BIT cycles at mid-bit.
//  RX stop sample: high -> byte pushed into RX FIFO; rx_valid rises 1 cycle after the stop sample.
//   Low -> byte dropped, frame_err pulses, FSM waits for rxd high before re-arming.
//   RX FIFO full at stop sample -> byte dropped, overrun pulses; existing contents are kept.
//  Baud counters are per-engine, width $clog2(CLKS_PER_BIT), reset to 0 on each state entry.
// CONFIGURATION
//  UART_PARITY_EN defined: TX inserts an even-parity bit after DATA.
//   RX checks that bit; a mismatch drops the byte and pulses frame_err.
//  UART_PARITY_EN undefined: no PARITY state in either FSM; frame is start+DATA_BITS+stop.
// STRUCTURE
//  uart_pkg: tx_state_t/rx_state_t enums, DATA_BITS_MAX=9, and function clog2_cnt(depth).
//  Sub-module uart_fifo #(WIDTH,DEPTH) is instantiated twice (TX, RX).
//   It provides full/empty/count and same-cycle push+pop.
//  Baud counters and FSMs stay inline in uart_transceiver.
// TESTING (CLKS_PER_BIT=16, DEPTH=4, DATA_BITS=8, txd looped to rxd unless noted)
//  1 Push 0xA5 at edge k -> txd low after k+2; bits 1,0,1,0,0,1,0,1 every 16 clk; then stop.
//    rx_data=0xA5, rx_valid one cycle after the mid-stop sample.
//  2 Push 0x01,0x02,0x03,0x04,0x05 back-to-back -> tx_ready=0 after the 4th is queued.
//    5th accepted once the first pop frees a slot; frames are contiguous; RX yields 01..05 in order.
//  3 Hold rx_ready=0 and send 5 frames -> rx_count=4 and overrun pulses once on frame 5.
//    rx_data stays 0x01.
//  4 Drive rxd directly: frame 0x3C with stop bit low -> frame_err pulse, rx_count unchanged.
//    A 4-clk low glitch on rxd -> no byte and no flag.
//  5 Assert rst_n=0 mid-DATA of a TX frame -> txd=1 and counts 0 immediately.
//    Next pushed byte is transmitted intact.
//  6 UART_PARITY_EN: 0x07 -> parity bit 1 on txd; flip the parity bit on injected rxd -> frame_err, byte dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encodings and FIFO count sizing.
package uart_pkg;

  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, including when full.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = clog2_cnt(DEPTH),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // When full, a push only lands if the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with TX/RX FIFOs and valid/ready ports.
// Define UART_PARITY_EN to add an even-parity bit after the data bits in both directions.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        txd,
  input  logic                        rxd,
  output logic [clog2_cnt(DEPTH)-1:0] tx_count,
  output logic [clog2_cnt(DEPTH)-1:0] rx_count,
  output logic                        tx_busy,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS_MAX + 1);
  localparam logic [BW-1:0] LAST      = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF      = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty;

  tx_state_t            tx_state;
  logic [BW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 txd_reg;

  rx_state_t            rx_state;
  logic [BW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rxd_meta, rxd_sync, rxd_prev;
  logic                 rx_push_reg, frame_err_reg, overrun_reg, rx_bad;
  logic [DATA_BITS-1:0] rx_byte_reg;

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign txd       = txd_reg;
  assign tx_busy   = (tx_state != TX_IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  // The head leaves the FIFO when idle, or back-to-back as the last stop bit ends.
  assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) ||
                  (tx_state == TX_STOP && tx_cnt == LAST && tx_idx == STOP_LAST));

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid && tx_ready), .wr_data(tx_data),
    .pop(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push_reg), .wr_data(rx_byte_reg),
    .pop(rx_ready), .rd_data(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

`ifdef UART_PARITY_EN
  logic tx_par, rx_par_bad;
  assign rx_bad = rx_par_bad;
`else
  assign rx_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd_reg  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_shift <= tx_head;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + BW'(1);
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_idx == BIT_LAST) begin
              tx_idx <= '0;
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
`else
              tx_state <= TX_STOP;
`endif
            end else tx_idx <= tx_idx + IW'(1);
          end else tx_cnt <= tx_cnt + BW'(1);
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt + BW'(1);
        end
`endif
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_idx == STOP_LAST) begin
              tx_idx <= '0;
              if (tx_pop) begin
                tx_state <= TX_START;
                tx_shift <= tx_head;
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_head;
`endif
              end else tx_state <= TX_IDLE;
            end else tx_idx <= tx_idx + IW'(1);
          end else tx_cnt <= tx_cnt + BW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase

      // Line level follows the state one cycle later, keeping every bit the same length.
      case (tx_state)
        TX_START: txd_reg <= 1'b0;
        TX_DATA:  txd_reg <= tx_shift[0];
`ifdef UART_PARITY_EN
        TX_PARITY: txd_reg <= tx_par;
`endif
        default:  txd_reg <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta      <= 1'b1;
      rxd_sync      <= 1'b1;
      rxd_prev      <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_push_reg   <= 1'b0;
      rx_byte_reg   <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
`endif
    end else begin
      rxd_meta      <= rxd;
      rxd_sync      <= rxd_meta;
      rxd_prev      <= rxd_sync;
      rx_push_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          // Edge-triggered start: after a framing error the line must return high first.
          if (rxd_prev && !rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
          end else rx_cnt <= rx_cnt + BW'(1);
        end
        RX_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == BIT_LAST) begin
              rx_idx <= '0;
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else rx_idx <= rx_idx + IW'(1);
          end else rx_cnt <= rx_cnt + BW'(1);
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= rxd_sync ^ (^rx_shift);
            rx_state   <= RX_STOP;
          end else rx_cnt <= rx_cnt + BW'(1);
        end
`endif
        RX_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rxd_sync || rx_bad) frame_err_reg <= 1'b1;
            else if (rx_full)        overrun_reg   <= 1'b1;
            else begin
              rx_push_reg <= 1'b1;
              rx_byte_reg <= rx_shift;
            end
          end else rx_cnt <= rx_cnt + BW'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver (CLKS_PER_BIT=16, DEPTH=4, DATA_BITS=8).
module tb_uart_transceiver;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = CPB * (DB + PAR + 2);
  // Edges from the TX push to rx_valid rising in loopback.
  localparam int RXV = 30 + CPB * (DB + PAR);

  logic       clk, rst_n;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       txd, rxd, rxd_drv, loop_en;
  logic [2:0] tx_count, rx_count;
  logic       tx_busy, frame_err, overrun;
  int         total = 0;
  int         bad = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .txd(txd), .rxd(rxd),
    .tx_count(tx_count), .rx_count(rx_count), .tx_busy(tx_busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    loop_en = 1'b1;
    rxd_drv = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    rxd_drv = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      step(CPB);
    end
    if (PAR != 0) begin
      rxd_drv = (^d) ^ flip;
      step(CPB);
    end
    rxd_drv = stop;
    step(CPB);
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if ({txd, tx_ready, rx_valid, tx_busy} !== 4'b1100) begin
      bad++; $display("FAIL reset_flags: got %b want 1100", {txd, tx_ready, rx_valid, tx_busy});
    end
    total++;
    if ({frame_err, overrun, tx_count, rx_count} !== 8'h00) begin
      bad++; $display("FAIL reset_counts: got %h want 00", {frame_err, overrun, tx_count, rx_count});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    $display("reset checked");
  endtask

  task automatic test_single();
    int t;
    logic [0:7] bits = 8'b10100101;  // 0xA5 on the line, LSB first
    loop_en = 1'b1;
    rx_ready = 1'b0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    t = 0;
    step(1); t = 1;
    total++;
    if ({txd, tx_busy} !== 2'b11) begin
      bad++; $display("FAIL single_k1: got %b want 11", {txd, tx_busy});
    end
    step(1); t = 2;
    total++;
    if (txd !== 1'b0) begin
      bad++; $display("FAIL single_start: got %b want 0", txd);
    end
    for (int i = 0; i < 8; i++) begin
      step(26 + 16 * i - t); t = 26 + 16 * i;
      total++;
      if (txd !== bits[i]) begin
        bad++; $display("FAIL single_bit%0d: got %b want %b", i, txd, bits[i]);
      end
    end
`ifdef UART_PARITY_EN
    step(26 + 128 - t); t = 26 + 128;
    total++;
    if (txd !== 1'b0) begin
      bad++; $display("FAIL single_parity: got %b want 0", txd);
    end
`endif
    step(26 + 16 * (8 + PAR) - t); t = 26 + 16 * (8 + PAR);
    total++;
    if (txd !== 1'b1) begin
      bad++; $display("FAIL single_stop: got %b want 1", txd);
    end
    step(RXV - 1 - t); t = RXV - 1;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL single_rxv_early: got %b want 0", rx_valid);
    end
    step(1);
    total++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
      bad++; $display("FAIL single_rx: got %b/%h want 1/a5", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL single_pop: got %b want 0", rx_valid);
    end
    $display("single frame a5 done");
  endtask

  task automatic push_five();
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(i + 1);
      tx_valid = 1'b1;
      step(1);
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] got [5];
    int n = 0;
    int last = 0;
    loop_en = 1'b1;
    rx_ready = 1'b1;
    push_five();
    total++;
    if ({tx_ready, tx_count} !== {1'b0, 3'd4}) begin
      bad++; $display("FAIL b2b_full: got %b/%0d want 0/4", tx_ready, tx_count);
    end
    for (int c = 5; c <= RXV + 4 * FRAME + 4; c++) begin
      step(1);
      if (rx_valid === 1'b1 && n < 5) begin
        got[n] = rx_data;
        last = c;
        $display("rx byte %h at edge %0d", rx_data, c);
        n++;
      end
    end
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL b2b_count: got %0d want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i] !== exp_b[i]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp_b[i]);
      end
    end
    total++;
    if (last !== RXV + 4 * FRAME) begin
      bad++; $display("FAIL b2b_contiguous: got %0d want %0d", last, RXV + 4 * FRAME);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int ov0;
    do_reset();
    ov0 = ov_cnt;
    push_five();
    step(RXV + 4 * FRAME + 20);
    total++;
    if (ov_cnt - ov0 !== 1) begin
      bad++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0);
    end
    total++;
    if ({rx_count, rx_data} !== {3'd4, 8'h01}) begin
      bad++; $display("FAIL overrun_keep: got %0d/%h want 4/01", rx_count, rx_data);
    end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    total++;
    if ({rx_count, rx_data} !== {3'd3, 8'h02}) begin
      bad++; $display("FAIL overrun_pop: got %0d/%h want 3/02", rx_count, rx_data);
    end
    $display("overrun scenario done");
  endtask

  task automatic test_frame_err();
    int fe0;
    do_reset();
    loop_en = 1'b0;
    step(4);
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    step(40);
    total++;
    if ({fe_cnt - fe0, rx_count} !== {32'd1, 3'd0}) begin
      bad++; $display("FAIL frame_err: got fe=%0d cnt=%0d want fe=1 cnt=0", fe_cnt - fe0, rx_count);
    end
    rxd_drv = 1'b0;
    step(4);
    rxd_drv = 1'b1;
    step(200);
    total++;
    if ({fe_cnt - fe0, rx_count} !== {32'd1, 3'd0}) begin
      bad++; $display("FAIL glitch: got fe=%0d cnt=%0d want fe=1 cnt=0", fe_cnt - fe0, rx_count);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    step(40);
    total++;
    if ({rx_count, rx_data} !== {3'd1, 8'h3C}) begin
      bad++; $display("FAIL inject_good: got %0d/%h want 1/3c", rx_count, rx_data);
    end
    $display("frame error and glitch done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(59);
    total++;
    if ({tx_busy, txd} !== 2'b10) begin
      bad++; $display("FAIL midframe_pre: got %b want 10", {tx_busy, txd});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({txd, tx_busy, tx_count, rx_count} !== {1'b1, 1'b0, 3'd0, 3'd0}) begin
      bad++; $display("FAIL midframe_reset: got %b want 10000000", {txd, tx_busy, tx_count, rx_count});
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(RXV + 5);
    total++;
    if ({rx_count, rx_data} !== {3'd1, 8'hC3}) begin
      bad++; $display("FAIL after_reset_tx: got %0d/%h want 1/c3", rx_count, rx_data);
    end
    $display("mid-frame reset done");
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int fe0;
    do_reset();
    tx_data = 8'h07;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(26 + 128);
    total++;
    if (txd !== 1'b1) begin
      bad++; $display("FAIL parity_tx: got %b want 1", txd);
    end
    step(RXV);
    total++;
    if ({rx_count, rx_data} !== {3'd1, 8'h07}) begin
      bad++; $display("FAIL parity_loop: got %0d/%h want 1/07", rx_count, rx_data);
    end
    loop_en = 1'b0;
    fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    step(40);
    total++;
    if ({fe_cnt - fe0, rx_count} !== {32'd1, 3'd1}) begin
      bad++; $display("FAIL parity_bad: got fe=%0d cnt=%0d want fe=1 cnt=1", fe_cnt - fe0, rx_count);
    end
    $display("parity done");
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    loop_en = 1'b1;
    rxd_drv = 1'b1;
    #3;
    rst_n = 1'b0;
    step(2);
    test_reset();
    rst_n = 1'b1;
    step(2);
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
